// File: rtl/acc_float.sv
// Sequential IEEE-754 single-precision accumulator: IDLE -> ALIGN -> ADD -> NORM -> ROUND per beat.
// Define ACC_FLOAT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module acc_float #(
  parameter int ALIGN_W = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_clear,
  input  logic        in_last,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        overflow
);

  localparam int LZW = $clog2(ALIGN_W + 1);
  localparam logic [ALIGN_W-1:0] ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        overflow_q, overflow_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        last_q, last_d;

  logic [ALIGN_W-1:0] big_m_q, big_m_d;
  logic [ALIGN_W-1:0] small_m_q, small_m_d;
  logic               big_s_q, big_s_d;
  logic               small_s_q, small_s_d;
  logic [7:0]         exp_q, exp_d;
  logic               inf_q, inf_d;
  logic               inf_s_q, inf_s_d;

  logic [ALIGN_W:0]   add_m_q, add_m_d;
  logic               add_s_q, add_s_d;

  logic [ALIGN_W-1:0] norm_m_q, norm_m_d;
  logic signed [9:0]  norm_e_q, norm_e_d;
  logic               norm_s_q, norm_s_d;
  logic               norm_z_q, norm_z_d;

  // Operand unpacking: exponent 0 is treated as zero, otherwise a hidden 1 is restored
  logic [31:0]        op   [2];
  logic [7:0]         op_e [2];
  logic [ALIGN_W-1:0] op_m [2];
  logic               op_s [2];

  assign op[0] = opa_q;
  assign op[1] = opb_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_s[gi] = op[gi][31];
      assign op_e[gi] = op[gi][30:23];
      assign op_m[gi] = (op[gi][30:23] == 8'd0) ? '0
                      : {1'b1, op[gi][22:0], {(ALIGN_W-24){1'b0}}};
    end
  endgenerate

  // ALIGN stage
  logic               al_swap;
  logic [7:0]         al_e_big, al_e_small, al_diff;
  logic [ALIGN_W-1:0] al_m_big, al_m_small, al_shifted;
  logic               al_lost;

  always_comb begin
    al_swap    = op_e[1] > op_e[0];
    al_e_big   = al_swap ? op_e[1] : op_e[0];
    al_e_small = al_swap ? op_e[0] : op_e[1];
    al_m_big   = al_swap ? op_m[1] : op_m[0];
    al_m_small = al_swap ? op_m[0] : op_m[1];
    al_diff    = al_e_big - al_e_small;
    if ({24'd0, al_diff} >= 32'(ALIGN_W)) begin
      al_shifted = '0;
      al_lost    = |al_m_small;
    end else begin
      al_shifted = al_m_small >> al_diff;
      al_lost    = |(al_m_small & ~(ONES << al_diff));
    end
  end

  // NORM stage leading-zero count; the highest set bit wins
  logic [LZW-1:0]    nm_lzc;
  logic signed [9:0] nm_exp_ext;

  always_comb begin
    nm_lzc = '0;
    for (int i = 0; i < ALIGN_W; i++) begin
      if (add_m_q[i]) nm_lzc = LZW'(ALIGN_W - 1 - i);
    end
  end

  assign nm_exp_ext = $signed({2'b00, exp_q});

  // ROUND stage
  logic [23:0]       rd_mant24;
  logic [24:0]       rd_mant25;
  logic [22:0]       rd_frac;
  logic signed [9:0] rd_e;
  logic              rd_g, rd_r, rd_st, rd_up;
  logic [31:0]       rd_res;
  logic              rd_ovf;

  assign rd_mant24 = norm_m_q[ALIGN_W-1 -: 24];
  assign rd_g      = norm_m_q[ALIGN_W-25];
  assign rd_r      = norm_m_q[ALIGN_W-26];
  assign rd_st     = |norm_m_q[ALIGN_W-27:0];

`ifdef ACC_FLOAT_RNE_EN
  assign rd_up = rd_g & (rd_r | rd_st | rd_mant24[0]);
`else
  logic unused_grs;
  assign rd_up      = 1'b0;
  assign unused_grs = rd_g | rd_r | rd_st;
`endif

  always_comb begin
    rd_mant25 = {1'b0, rd_mant24} + {24'd0, rd_up};
    rd_frac   = rd_mant25[24] ? rd_mant25[23:1] : rd_mant25[22:0];
    rd_e      = norm_e_q + $signed({9'd0, rd_mant25[24]});
    rd_ovf    = 1'b0;
    if (inf_q) begin
      rd_res = {inf_s_q, 8'hFF, 23'd0};
      rd_ovf = 1'b1;
    end else if (norm_z_q) begin
      rd_res = {norm_s_q, 31'd0};
    end else if (rd_e >= 10'sd255) begin
      rd_res = {norm_s_q, 8'hFF, 23'd0};
      rd_ovf = 1'b1;
    end else begin
      rd_res = {norm_s_q, rd_e[7:0], rd_frac};
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    sum_d       = sum_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    last_d      = last_q;
    big_m_d     = big_m_q;
    small_m_d   = small_m_q;
    big_s_d     = big_s_q;
    small_s_d   = small_s_q;
    exp_d       = exp_q;
    inf_d       = inf_q;
    inf_s_d     = inf_s_q;
    add_m_d     = add_m_q;
    add_s_d     = add_s_q;
    norm_m_d    = norm_m_q;
    norm_e_d    = norm_e_q;
    norm_s_d    = norm_s_q;
    norm_z_d    = norm_z_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          opa_d   = in_clear ? 32'd0 : sum_q;
          opb_d   = in_data;
          last_d  = in_last;
          if (in_clear) overflow_d = 1'b0;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        big_m_d   = al_m_big;
        small_m_d = {al_shifted[ALIGN_W-1:1], al_shifted[0] | al_lost};
        big_s_d   = al_swap ? op_s[1] : op_s[0];
        small_s_d = al_swap ? op_s[0] : op_s[1];
        exp_d     = al_e_big;
        inf_d     = (op_e[0] == 8'hFF) || (op_e[1] == 8'hFF);
        inf_s_d   = (op_e[1] == 8'hFF) ? op_s[1] : op_s[0];
        state_d   = S_ADD;
      end
      S_ADD: begin
        if (big_s_q == small_s_q) begin
          add_m_d = {1'b0, big_m_q} + {1'b0, small_m_q};
          add_s_d = big_s_q;
        end else if (big_m_q >= small_m_q) begin
          add_m_d = {1'b0, big_m_q} - {1'b0, small_m_q};
          add_s_d = big_s_q;
        end else begin
          add_m_d = {1'b0, small_m_q} - {1'b0, big_m_q};
          add_s_d = small_s_q;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        norm_s_d = add_s_q;
        norm_z_d = 1'b0;
        if (add_m_q == '0) begin
          norm_m_d = '0;
          norm_e_d = '0;
          norm_s_d = 1'b0;
          norm_z_d = 1'b1;
        end else if (add_m_q[ALIGN_W]) begin
          norm_m_d = {add_m_q[ALIGN_W:2], add_m_q[1] | add_m_q[0]};
          norm_e_d = nm_exp_ext + 10'sd1;
        end else begin
          norm_m_d = add_m_q[ALIGN_W-1:0] << nm_lzc;
          norm_e_d = nm_exp_ext - $signed(10'(nm_lzc));
        end
        // Underflow flushes to a signed zero; there is no subnormal path
        if (add_m_q != '0 && norm_e_d <= 10'sd0) norm_z_d = 1'b1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        sum_d = rd_res;
        if (rd_ovf) overflow_d = 1'b1;
        if (last_q) begin
          out_data_d  = rd_res;
          out_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      sum_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      last_q      <= 1'b0;
      big_m_q     <= '0;
      small_m_q   <= '0;
      big_s_q     <= 1'b0;
      small_s_q   <= 1'b0;
      exp_q       <= '0;
      inf_q       <= 1'b0;
      inf_s_q     <= 1'b0;
      add_m_q     <= '0;
      add_s_q     <= 1'b0;
      norm_m_q    <= '0;
      norm_e_q    <= '0;
      norm_s_q    <= 1'b0;
      norm_z_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      sum_q       <= sum_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      last_q      <= last_d;
      big_m_q     <= big_m_d;
      small_m_q   <= small_m_d;
      big_s_q     <= big_s_d;
      small_s_q   <= small_s_d;
      exp_q       <= exp_d;
      inf_q       <= inf_d;
      inf_s_q     <= inf_s_d;
      add_m_q     <= add_m_d;
      add_s_q     <= add_s_d;
      norm_m_q    <= norm_m_d;
      norm_e_q    <= norm_e_d;
      norm_s_q    <= norm_s_d;
      norm_z_q    <= norm_z_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_acc_float.sv
// Directed self-checking bench for acc_float; rounding expectations follow ACC_FLOAT_RNE_EN.
module tb_acc_float;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_clear;
  logic        in_last;
  logic        out_valid;
  logic [31:0] out_data;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  acc_float #(.ALIGN_W(27)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_clear  (in_clear),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat; ov/rdy are sampled just after edges 0..4 of the beat, res after edge 4.
  task automatic send_beat(input logic [31:0] data, input logic clr, input logic lst,
                           output logic [4:0] ov, output logic [4:0] rdy, output logic [31:0] res);
    int tries;
    ov  = '0;
    rdy = '0;
    res = '0;
    @(negedge clk);
    in_data  = data;
    in_clear = clr;
    in_last  = lst;
    in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ov[0]  = out_valid;
    rdy[0] = in_ready;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk);
      #1;
      ov[k]  = out_valid;
      rdy[k] = in_ready;
    end
    res = out_data;
    $display("beat data=%h clear=%b last=%b -> out_valid_trace=%b ready_trace=%b out_data=%h overflow=%b",
             data, clr, lst, ov, rdy, res, overflow);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    in_clear = 1'b1;
    in_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
    in_valid = 1'b0;
    $display("reset released in_ready=%b out_data=%h", in_ready, out_data);
  endtask

  task automatic test_sum;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    send_beat(32'h3F800000, 1'b1, 1'b0, ov, rdy, r);
    total++; if (ov !== 5'b00000) begin bad++; $display("FAIL sum_no_pulse_mid got=%b want=00000", ov); end
    send_beat(32'h40000000, 1'b0, 1'b0, ov, rdy, r);
    send_beat(32'h3FC00000, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h40900000) begin bad++; $display("FAIL sum_result got=%h want=40900000", r); end
    total++; if (ov !== 5'b10000) begin bad++; $display("FAIL sum_valid_timing got=%b want=10000", ov); end
    total++; if (rdy !== 5'b10000) begin bad++; $display("FAIL sum_ready_timing got=%b want=10000", rdy); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sum_pulse_width got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h40900000) begin bad++; $display("FAIL sum_hold got=%h want=40900000", out_data); end
  endtask

  task automatic test_cancel;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    send_beat(32'h3F800000, 1'b1, 1'b0, ov, rdy, r);
    send_beat(32'hBF800000, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h00000000) begin bad++; $display("FAIL cancel_result got=%h want=00000000", r); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL cancel_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_overflow;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    send_beat(32'h7F7FFFFF, 1'b1, 1'b0, ov, rdy, r);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b want=0", overflow); end
    send_beat(32'h7F7FFFFF, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h7F800000) begin bad++; $display("FAIL ovf_result got=%h want=7F800000", r); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    send_beat(32'h3F800000, 1'b1, 1'b1, ov, rdy, r);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", overflow); end
    total++; if (r !== 32'h3F800000) begin bad++; $display("FAIL ovf_clear_last got=%h want=3F800000", r); end
  endtask

  task automatic test_round;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    logic [31:0] want;
`ifdef ACC_FLOAT_RNE_EN
    want = 32'h3F800001;
`else
    want = 32'h3F800000;
`endif
    send_beat(32'h3F800000, 1'b1, 1'b0, ov, rdy, r);
    send_beat(32'h33C00000, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== want) begin bad++; $display("FAIL round_above_half got=%h want=%h", r, want); end
    send_beat(32'h3F800000, 1'b1, 1'b0, ov, rdy, r);
    send_beat(32'h33800000, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h3F800000) begin bad++; $display("FAIL round_tie got=%h want=3F800000", r); end
  endtask

  task automatic test_sign;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    send_beat(32'h40000000, 1'b1, 1'b0, ov, rdy, r);
    send_beat(32'hC0400000, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== 32'hBF800000) begin bad++; $display("FAIL sign_negative got=%h want=BF800000", r); end
  endtask

  task automatic test_stall;
    int acc[$];
    @(negedge clk);
    in_data  = 32'h0;
    in_clear = 1'b1;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready) acc.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    $display("stall accepted %0d beats in 30 cycles", acc.size());
    total++; if (acc.size() != 6) begin bad++; $display("FAIL stall_count got=%0d want=6", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] != 5) begin
        bad++;
        $display("FAIL stall_gap got=%0d want=5", acc[i] - acc[i-1]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_inf;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    send_beat(32'h7F800000, 1'b1, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h7F800000) begin bad++; $display("FAIL inf_result got=%h want=7F800000", r); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL inf_overflow got=%b want=1", overflow); end
  endtask

  task automatic test_abort;
    logic [4:0] ov, rdy;
    logic [31:0] r;
    logic seen;
    send_beat(32'h40000000, 1'b1, 1'b0, ov, rdy, r);
    @(negedge clk);
    in_data  = 32'h3F800000;
    in_clear = 1'b0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b want=0", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL abort_out_data got=%h want=00000000", out_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL abort_overflow got=%b want=0", overflow); end
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    $display("abort done out_valid_seen=%b", seen);
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b want=0", seen); end
    send_beat(32'h3F800000, 1'b0, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h3F800000) begin bad++; $display("FAIL abort_sum_zeroed got=%h want=3F800000", r); end
    send_beat(32'h00000000, 1'b1, 1'b1, ov, rdy, r);
    total++; if (r !== 32'h00000000) begin bad++; $display("FAIL abort_clear_zero got=%h want=00000000", r); end
    total++; if (ov !== 5'b10000) begin bad++; $display("FAIL abort_clear_valid got=%b want=10000", ov); end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_clear = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_sum();
    test_cancel();
    test_overflow();
    test_round();
    test_sign();
    test_stall();
    test_inf();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/acc_float.md
# acc_float

Sequential IEEE-754 single-precision accumulator sitting directly downstream of the `mul_float` product stage. It accepts one 32-bit float product per handshake and adds it into an internal running sum through a fixed 4-cycle align/add/normalize/round state machine. On the beat marked last, it emits the finished sum. Together with the multiplier it forms the dot-product path.

## Interface
- `ALIGN_W`, default 27: aligned mantissa datapath width, 24 significand bits plus guard/round/sticky; legal values ≥ 27.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product word valid.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `in_data`  in  32  float product: sign [31], exponent [30:23], fraction [22:0].
- `in_clear`  in  1  sampled with the beat; treat the running sum as +0 before adding `in_data`.
- `in_last`  in  1  sampled with the beat; publish the sum after this add.
- `out_valid`  out  1  one-cycle pulse; `out_data` holds the final sum.
- `out_data`  out  32  final accumulated float; held until the next `out_valid`.
- `overflow`  out  1  sticky; cleared by a beat with `in_clear=1`.

## Operation
- **Reset values.** Reset is asynchronous and active-low. While `rst_n`=0 the outputs are `in_ready`=0, `out_valid`=0, `out_data`=0 and `overflow`=0, the internal sum is +0, and the state is IDLE. `in_ready` rises in the first cycle after `rst_n` is released.
- **Input handshake.** A beat is accepted on a clock edge where `in_valid`=1 and `in_ready`=1. `in_data`, `in_clear` and `in_last` are latched on that edge.
- **IDLE → ALIGN.** Operand A is the sum, or +0 if `in_clear`=1; operand B is `in_data`.
  - An exponent of 0 means the operand is zero; no subnormals are supported.
  - Both operands are unpacked with a hidden 1.
  - The smaller-exponent mantissa is shifted right by the exponent difference in one step. Bits shifted past position 0 are OR-ed into sticky. A difference ≥ `ALIGN_W` gives mantissa 0 with sticky = (operand ≠ 0).
- **ALIGN → ADD.** Equal signs add the mantissas; unequal signs subtract the smaller magnitude from the larger, and the result takes the sign of the larger. ALIGN_W+1 bits are kept for the carry.
- **ADD → NORM.**
  - On a carry, shift right 1 and increment the exponent; the dropped bit folds into sticky.
  - Otherwise a leading-zero count shifts left in one step and the exponent decreases by that count.
  - An exactly zero mantissa gives the result +0.
  - An exponent that falls to ≤ 0 flushes the result to ±0.
- **NORM → ROUND.**
  - Rounding is applied per the Configuration section. A rounding carry renormalizes and increments the exponent.
  - An exponent ≥ 255 gives ±Inf (0x7F800000 with the sign) and sets `overflow`.
  - Any operand with exponent 255 gives the same ±Inf result and sets `overflow`.
  - The result is written to the sum.
- **ROUND → IDLE.** If the latched `in_last`=1, `out_data` ← sum and `out_valid`=1 for this one cycle.
- `in_clear` and `in_last` may both be 1 on the same beat. The output is then just the rounded `in_data`.
- Beats with neither flag simply accumulate.

## Timing
- Every beat takes a fixed 4 cycles, with states IDLE → ALIGN → ADD → NORM → ROUND.
- Number the acceptance edge as edge 0:
  - the FSM is in ALIGN after edge 0;
  - the sum updates at edge 4;
  - `out_valid` is high in the cycle after edge 4 when `in_last` was set;
  - `in_ready`=1 again in the cycle after edge 4.
- Maximum throughput is 1 beat per 5 cycles.
- `in_ready` is deasserted from edge 0 through edge 4. `in_valid` asserted during that window is ignored, and upstream holds its data.
- `rst_n` asserted mid-beat aborts immediately. The beat is lost and the block returns to its reset values.
- No back-pressure on the output; a consumer must capture `out_data` on the `out_valid` pulse.

## Configuration
- `ACC_FLOAT_RNE_EN` defined: round-to-nearest-even.
  - Round up when guard=1 and (round | sticky | lsb)=1.
- `ACC_FLOAT_RNE_EN` undefined: truncate.
  - Guard, round and sticky are discarded.
  - The remaining datapath and timing are identical.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `in_ready`=0 and `out_data`=0. After release, `in_ready`=1 in the first cycle.
- Sum: beats 0x3F800000 (clear), 0x40000000, 0x3FC00000 (last) → `out_data`=0x40900000 (4.5). `out_valid` pulses in the cycle after edge 4 of the third beat.
- Cancellation: 0x3F800000 (clear), then 0xBF800000 (last) → `out_data`=0x00000000 and `overflow`=0.
- Overflow: 0x7F7FFFFF (clear), then 0x7F7FFFFF (last) → `out_data`=0x7F800000 and `overflow`=1. The next clear beat drops `overflow` to 0.
- Rounding:
  - 0x3F800000 (clear), then 0x33C00000 (last) → 0x3F800001 with `ACC_FLOAT_RNE_EN`, 0x3F800000 without.
  - The tie case 0x33800000 → 0x3F800000 in both builds.
- Stall and abort: hold `in_valid`=1 continuously → a beat is accepted every 5th cycle. Pulse `rst_n`=0 in NORM → no `out_valid`, and the sum reads +0 on a following clear+last beat of 0x00000000.
